semaphore_access_arbiter: RTL and testbench

- Shares one semaphored memory array (15 semaphore bits, addresses 1..15) between NUM_CORES PLC cores.
- Each core posts one request at a time: read-acquire, write, or release. The block picks one requester round-robin, drives the array's write or read strobe interface, waits for the matching RDY, then returns a one-cycle acknowledge with a status bit.
- Sits between the core cluster and the semaphore array.

---
 rtl/sem_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/semaphore_access_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_semaphore_access_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sem_arb_pkg.sv
// Shared types and constants for the semaphore access arbiter.
package sem_arb_pkg;

    // Semaphore bits live at addresses 1..SEM_ARRAY_SIZE; address 0 is never valid.
    localparam int SEM_ARRAY_SIZE = 15;
    localparam int ADDR_W         = 4;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_e;

    function automatic logic addr_ok(input int unsigned addr);
        return (addr != 0) && (addr <= SEM_ARRAY_SIZE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after ptr_i wins,
// wrapping around, so ptr_i itself has the lowest priority.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_grant_o
);

    logic [IDX_W-1:0] cand;

    // Scan candidates in priority order starting one past the pointer.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        cand        = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % N);
            if (!any_grant_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                any_grant_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaphore_access_arbiter.sv
// Round-robin arbiter between NUM_CORES cores and one semaphore array.
// One array operation is in flight at a time; every output is registered.
// Optional WAIT-state timeout: define SEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pick a requester, latch its op/addr/wdata, raise strobes for ISSUE
// ISSUE | strobes high for this single cycle; bad address/op skips to DONE
// WAIT  | wait for the matching RDY (or timeout when enabled)
// DONE  | one-cycle ack + status, advance the round-robin pointer
module semaphore_access_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_W         = sem_arb_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [2*NUM_CORES-1:0]        req_op,
    input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
    input  logic [NUM_CORES-1:0]          req_wdata,
    output logic [NUM_CORES-1:0]          req_ack,
    output logic                          req_ok,
    output logic [ADDR_W-1:0]             WR_Addr,
    output logic                          WR,
    output logic                          WR_EN,
    input  logic                          WR_RDY,
    output logic [ADDR_W-1:0]             RD_Addr,
    output logic                          RD,
    output logic                          RD_EN,
    output logic                          RD_Release,
    input  logic                          RD_RDY
);

    import sem_arb_pkg::*;

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    op_e                    op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   wdata_q, wdata_d;
    logic                   vld_q, vld_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_CORES-1:0]   clr_q, clr_d;
    logic [NUM_CORES-1:0]   ack_q, ack_d;
    logic                   ok_q, ok_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic                   wr_q, wr_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   rd_q, rd_d;
    logic                   rd_en_q, rd_en_d;
    logic                   rel_q, rel_d;

    logic [NUM_CORES-1:0]   arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [1:0]             sel_op;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_wdata;
    logic                   sel_vld;
    logic                   rdy;
    logic                   to_hit;

    // The core acked last cycle is masked for one IDLE cycle so a held request
    // is not mistaken for a fresh one.
    rr_arbiter #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i       (req_valid & ~clr_q),
        .ptr_i       (ptr_q),
        .grant_o     (arb_gnt),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    // Mux the granted core's request fields.
    always_comb begin
        sel_op    = '0;
        sel_addr  = '0;
        sel_wdata = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (arb_gnt[i]) begin
                sel_op    = req_op[2*i +: 2];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[i];
            end
        end
    end

    assign sel_vld = addr_ok(32'(sel_addr)) && (op_e'(sel_op) != OP_RSVD);
    assign rdy     = (op_q == OP_WRITE) ? WR_RDY : RD_RDY;

`ifdef SEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    // WAIT-cycle counter, cleared whenever a new operation is accepted.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE && arb_any) begin
            to_cnt_d = '0;
        end else if (state_q == WAIT) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign to_hit = (to_cnt_q == TO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    // Next-state and next-output logic; strobes and ack are computed one cycle
    // early so that the registered outputs line up with ISSUE and DONE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        vld_d     = vld_q;
        ptr_d     = ptr_q;
        clr_d     = '0;
        ack_d     = '0;
        ok_d      = 1'b0;
        wr_addr_d = '0;
        wr_d      = 1'b0;
        wr_en_d   = 1'b0;
        rd_addr_d = '0;
        rd_d      = 1'b0;
        rd_en_d   = 1'b0;
        rel_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = ISSUE;
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    op_d    = op_e'(sel_op);
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    vld_d   = sel_vld;
                    if (sel_vld) begin
                        case (op_e'(sel_op))
                            OP_WRITE: begin
                                wr_en_d   = 1'b1;
                                wr_d      = sel_wdata;
                                wr_addr_d = sel_addr;
                            end
                            OP_READ: begin
                                rd_en_d   = 1'b1;
                                rd_d      = 1'b1;
                                rd_addr_d = sel_addr;
                            end
                            OP_RELEASE: begin
                                rd_en_d   = 1'b1;
                                rel_d     = 1'b1;
                                rd_addr_d = sel_addr;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ISSUE: begin
                if (!vld_q) begin
                    state_d = DONE;
                    ack_d   = gnt_q;
                    ok_d    = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rdy) begin
                    state_d = DONE;
                    ack_d   = gnt_q;
                    ok_d    = 1'b1;
                end else if (to_hit) begin
                    state_d = DONE;
                    ack_d   = gnt_q;
                    ok_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = gidx_q;
                clr_d   = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= 1'b0;
            vld_q     <= 1'b0;
            ptr_q     <= IDX_W'(NUM_CORES - 1);
            clr_q     <= '0;
            ack_q     <= '0;
            ok_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            vld_q     <= vld_d;
            ptr_q     <= ptr_d;
            clr_q     <= clr_d;
            ack_q     <= ack_d;
            ok_q      <= ok_d;
            wr_addr_q <= wr_addr_d;
            wr_q      <= wr_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            rd_en_q   <= rd_en_d;
            rel_q     <= rel_d;
        end
    end

    assign req_ack    = ack_q;
    assign req_ok     = ok_q;
    assign WR_Addr    = wr_addr_q;
    assign WR         = wr_q;
    assign WR_EN      = wr_en_q;
    assign RD_Addr    = rd_addr_q;
    assign RD         = rd_q;
    assign RD_EN      = rd_en_q;
    assign RD_Release = rel_q;

endmodule

// File: tb/tb_semaphore_access_arbiter.sv
// Bench for semaphore_access_arbiter: table of single transactions plus
// hand-written contention, stall, stale-hold, drop and reset sequences.
// Array strobes and acks are checked by a negedge monitor against queues.
module tb_semaphore_access_arbiter;

    import sem_arb_pkg::*;

    localparam int NC = 4;
    localparam int AW = 4;
`ifdef SEM_ARB_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     req_valid;
    logic [2*NC-1:0]   req_op;
    logic [AW*NC-1:0]  req_addr;
    logic [NC-1:0]     req_wdata;
    logic [NC-1:0]     req_ack;
    logic              req_ok;
    logic [AW-1:0]     WR_Addr;
    logic              WR;
    logic              WR_EN;
    logic              WR_RDY;
    logic [AW-1:0]     RD_Addr;
    logic              RD;
    logic              RD_EN;
    logic              RD_Release;
    logic              RD_RDY;

    semaphore_access_arbiter #(
        .NUM_CORES      (NC),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ack    (req_ack),
        .req_ok     (req_ok),
        .WR_Addr    (WR_Addr),
        .WR         (WR),
        .WR_EN      (WR_EN),
        .WR_RDY     (WR_RDY),
        .RD_Addr    (RD_Addr),
        .RD         (RD),
        .RD_EN      (RD_EN),
        .RD_Release (RD_Release),
        .RD_RDY     (RD_RDY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] ack;
        logic          ok;
    } exp_t;

    typedef struct {
        logic          we;
        logic          re;
        logic          rd;
        logic          rel;
        logic [AW-1:0] addr;
        logic          wd;
    } acc_t;

    typedef struct {
        int            core;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic          wd;
        logic          exp_ok;
        logic          exp_acc;
        int            exp_lat;
    } vec_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   total = 0;
    int   bad = 0;
    int   strobe_cnt = 0;

    vec_t vecs[7];
    vec_t tvec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic acc_t mk_acc(input logic [1:0] op, input logic [AW-1:0] a, input logic wd);
        acc_t r;
        r.we   = (op == 2'b01);
        r.re   = (op == 2'b00) || (op == 2'b10);
        r.rd   = (op == 2'b00);
        r.rel  = (op == 2'b10);
        r.addr = a;
        r.wd   = (op == 2'b01) ? wd : 1'b0;
        return r;
    endfunction

    task automatic push_exp(input int c, input logic ok);
        exp_t e;
        e.ack = NC'(1) << c;
        e.ok  = ok;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int c, input logic [1:0] op, input logic [AW-1:0] a, input logic wd);
        req_op[2*c +: 2]    = op;
        req_addr[AW*c +: AW] = a;
        req_wdata[c]        = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every strobe and every ack must match the head of its queue.
    logic [8:0]      mon_act;
    logic [NC:0]     mon_ack;
    acc_t            mon_a;
    exp_t            mon_e;
    always @(negedge clk) begin
        if (WR_EN || RD_EN) begin
            strobe_cnt++;
            mon_act = {WR_EN, RD_EN, RD, RD_Release, (WR_EN ? WR_Addr : RD_Addr), (WR_EN ? WR : 1'b0)};
            if (acc_q.size() == 0) begin
                chk("unexpected_strobe", 64'(mon_act), 64'd0);
            end else begin
                mon_a = acc_q.pop_front();
                chk("strobe_content", 64'(mon_act),
                    64'({mon_a.we, mon_a.re, mon_a.rd, mon_a.rel, mon_a.addr, mon_a.wd}));
            end
        end
        if (req_ack != '0) begin
            mon_ack = {req_ack, req_ok};
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'(mon_ack), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_ok", 64'(mon_ack), 64'({mon_e.ack, mon_e.ok}));
            end
        end
    end

    // One isolated transaction with RDY held high; checks ISSUE strobes and latency.
    task automatic apply_vec(input int v, input vec_t t);
        int  n;
        bit  seen;
        acc_t a;
        a = mk_acc(t.op, t.addr, t.wd);
        push_exp(t.core, t.exp_ok);
        if (t.exp_acc) acc_q.push_back(a);
        set_req(t.core, t.op, t.addr, t.wd);
        req_valid[t.core] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 1)
                chk($sformatf("vec%0d_issue_strobes", v), 64'({WR_EN, RD_EN}),
                    64'({t.exp_acc & a.we, t.exp_acc & a.re}));
            if (req_ack[t.core]) seen = 1;
        end
        req_valid[t.core] = 1'b0;
        chk($sformatf("vec%0d_latency", v), 64'(seen ? n : -1), 64'(t.exp_lat));
        tick();
        tick();
    endtask

    initial begin
        int  n, k, m, rel_cnt, early, s0;
        bit  seen;
        int  ack_cyc[3];

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        WR_RDY    = 1'b1;
        RD_RDY    = 1'b1;

        //           core op     addr   wd    ok    acc   lat
        vecs[0] = '{1, 2'b01, 4'd5,  1'b1, 1'b1, 1'b1, 3};
        vecs[1] = '{0, 2'b00, 4'd0,  1'b0, 1'b0, 1'b0, 2};
        vecs[2] = '{2, 2'b10, 4'd15, 1'b0, 1'b1, 1'b1, 3};
        vecs[3] = '{3, 2'b11, 4'd3,  1'b0, 1'b0, 1'b0, 2};
        vecs[4] = '{0, 2'b01, 4'd1,  1'b0, 1'b1, 1'b1, 3};
        vecs[5] = '{2, 2'b00, 4'd9,  1'b0, 1'b1, 1'b1, 3};
        vecs[6] = '{1, 2'b01, 4'd15, 1'b1, 1'b1, 1'b1, 3};

        do_reset();
        chk("reset_outputs",
            64'({req_ack, req_ok, WR_Addr, WR, WR_EN, RD_Addr, RD, RD_EN, RD_Release}), 64'd0);

        for (int v = 0; v < 7; v++) apply_vec(v, vecs[v]);

        // Contention straight after reset: cores 0,2,3 -> order 0,2,3.
        do_reset();
        s0 = strobe_cnt;
        for (int c = 0; c < NC; c++) set_req(c, 2'b01, AW'(10 + c), c[0]);
        push_exp(0, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd10, 1'b0));
        push_exp(2, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd12, 1'b0));
        push_exp(3, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd13, 1'b1));
        ack_cyc = '{0, 0, 0};
        req_valid = 4'b1101;
        n = 0;
        k = 0;
        while (k < 3 && n < 60) begin
            tick();
            n++;
            if (req_ack != '0) begin
                ack_cyc[k] = n;
                k++;
                req_valid = req_valid & ~req_ack;
            end
        end
        req_valid = '0;
        chk("cont_ack_count", 64'(k), 64'd3);
        chk("cont_ack_cycles", {ack_cyc[0][15:0], ack_cyc[1][15:0], ack_cyc[2][15:0]},
            {16'd3, 16'd7, 16'd11});
        tick();
        tick();
        chk("cont_strobe_count", 64'(strobe_cnt - s0), 64'd3);

        // Stalled ready on a release.
        RD_RDY = 1'b0;
        set_req(3, 2'b10, 4'd15, 1'b0);
        push_exp(3, 1'b1);
        acc_q.push_back(mk_acc(2'b10, 4'd15, 1'b0));
        rel_cnt = 0;
        early = 0;
        req_valid[3] = 1'b1;
        for (int i = 0; i < STALL; i++) begin
            tick();
            if (RD_Release) rel_cnt++;
            if (req_ack != '0) early++;
        end
        RD_RDY = 1'b1;
        m = 0;
        seen = 0;
        while (!seen && m < 10) begin
            tick();
            m++;
            if (RD_Release) rel_cnt++;
            if (req_ack[3]) seen = 1;
        end
        req_valid[3] = 1'b0;
        chk("stall_no_early_ack", 64'(early), 64'd0);
        chk("stall_release_pulses", 64'(rel_cnt), 64'd1);
        chk("stall_ack_after_rdy", 64'(seen && m >= 1 && m <= 2), 64'd1);
        tick();
        tick();

        // Stale hold: request kept high across its ack is taken again only
        // after the one-cycle clear window.
        set_req(1, 2'b01, 4'd2, 1'b0);
        push_exp(1, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd2, 1'b0));
        push_exp(1, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd2, 1'b0));
        ack_cyc = '{0, 0, 0};
        req_valid[1] = 1'b1;
        n = 0;
        k = 0;
        while (k < 2 && n < 40) begin
            tick();
            n++;
            if (req_ack[1]) begin
                ack_cyc[k] = n;
                k++;
            end
        end
        req_valid[1] = 1'b0;
        chk("stale_hold_ack_cycles", {ack_cyc[0][15:0], ack_cyc[1][15:0]}, {16'd3, 16'd8});
        tick();
        tick();

        // Requester drops valid during ISSUE; ack still arrives.
        set_req(2, 2'b01, 4'd7, 1'b1);
        push_exp(2, 1'b1);
        acc_q.push_back(mk_acc(2'b01, 4'd7, 1'b1));
        req_valid[2] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 1) req_valid[2] = 1'b0;
            if (req_ack[2]) seen = 1;
        end
        chk("drop_mid_op_latency", 64'(seen ? n : -1), 64'd3);
        tick();
        tick();

        // Reset while the write strobe is high: it must clear at once.
        set_req(0, 2'b01, 4'd3, 1'b1);
        req_valid[0] = 1'b1;
        tick();
        chk("issue_strobe_before_reset", 64'({WR_EN, WR_Addr}), 64'({1'b1, 4'd3}));
        #1 rst_n = 1'b0;
        #1 chk("async_reset_in_issue", 64'({WR_EN, WR, WR_Addr, RD_EN}), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset during WAIT: no ack, then core 0 wins first.
        RD_RDY = 1'b0;
        set_req(1, 2'b00, 4'd4, 1'b0);
        acc_q.push_back(mk_acc(2'b00, 4'd4, 1'b0));
        req_valid[1] = 1'b1;
        repeat (4) tick();
        #1 rst_n = 1'b0;
        #1 chk("async_reset_in_wait",
               64'({req_ack, req_ok, WR_Addr, WR, WR_EN, RD_Addr, RD, RD_EN, RD_Release}), 64'd0);
        req_valid = '0;
        RD_RDY = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        set_req(0, 2'b01, 4'd8, 1'b1);
        set_req(1, 2'b01, 4'd9, 1'b0);
        push_exp(0, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd8, 1'b1));
        push_exp(1, 1'b1); acc_q.push_back(mk_acc(2'b01, 4'd9, 1'b0));
        ack_cyc = '{0, 0, 0};
        req_valid = 4'b0011;
        n = 0;
        k = 0;
        while (k < 2 && n < 40) begin
            tick();
            n++;
            if (req_ack != '0) begin
                ack_cyc[k] = n;
                k++;
                req_valid = req_valid & ~req_ack;
            end
        end
        req_valid = '0;
        chk("post_reset_ack_cycles", {ack_cyc[0][15:0], ack_cyc[1][15:0]}, {16'd3, 16'd7});
        tick();
        tick();

`ifdef SEM_ARB_TIMEOUT_EN
        // Timeout: 8 WAIT cycles without RD_RDY, then a normal request.
        RD_RDY = 1'b0;
        set_req(2, 2'b00, 4'd6, 1'b0);
        push_exp(2, 1'b0);
        acc_q.push_back(mk_acc(2'b00, 4'd6, 1'b0));
        req_valid[2] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (req_ack[2]) seen = 1;
        end
        req_valid[2] = 1'b0;
        RD_RDY = 1'b1;
        chk("timeout_latency", 64'(seen ? n : -1), 64'd10);
        tick();
        tick();
        tvec = '{0, 2'b01, 4'd3, 1'b1, 1'b1, 1'b1, 3};
        apply_vec(7, tvec);
`endif

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size() + acc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
